hook_motion_controller: RTL and testbench
=========================================

# hook_motion_controller

Sequences the Gold Miner hook's position on screen. The block sweeps the hook horizontally at the top while idle. It drops the hook on a fire command, then retracts it at a speed reduced by the weight of any grabbed item. It sits between the game-control logic (button, collision detector) and the square/bitmap object that draws the hook, driving that object's `topLeftX`/`topLeftY` once per video frame.

## Interface
- `HOME_X`, 300: hook X after reset.
- `TOP_Y`, 40: resting Y while swinging; retract end point.
- `MIN_X`, 40: left swing bound.
- `MAX_X`, 560: right swing bound.
- `MAX_Y`, 440: drop floor.
- `SWING_SPEED`, 2: pixels/frame in X while swinging.
- `DOWN_SPEED`, 4: pixels/frame in Y while dropping.
- `UP_SPEED`, 4: unloaded retract pixels/frame.
- `clk  in  1  system clock`
- `resetN  in  1  reset, synchronous, active-high (asserted = 1)`
- `startOfFrame  in  1  one-cycle pulse, once per VGA frame`
- `fire  in  1  player drop request, any length`
- `collision  in  1  hook touched an item, any length`
- `itemWeight  in  4  weight of the touched item, valid with collision`
- `topLeftX  out  11 signed  hook X for the drawing object`
- `topLeftY  out  11 signed  hook Y for the drawing object`
- `hookState  out  2  SWING=0, DOWN=1, UP=2`
- `grabbed  out  1  an item is attached during UP`
- `retractDone  out  1  one-cycle pulse when the hook returns to TOP_Y`

## Operation
- Reset values: `topLeftX`=`HOME_X`, `topLeftY`=`TOP_Y`, `hookState`=SWING, direction=+1, `grabbed`=0, `retractDone`=0, all latches cleared.
- Event latches (sticky, cleared when consumed):
  - `fireLat` sets on `fire` only in SWING.
  - `colLat` sets on `collision` only in DOWN and captures `itemWeight` on the first set.
  - `fire` in DOWN/UP and `collision` in SWING/UP are ignored.
- All motion and state changes happen only on a `startOfFrame` cycle.
- SWING:
  - If `fireLat` is set: go to DOWN, clear `fireLat`, position unchanged this frame.
  - Otherwise: X += dir*`SWING_SPEED`. If the result is ≥`MAX_X`, clamp to `MAX_X` and set dir=-1. If the result is ≤`MIN_X`, clamp to `MIN_X` and set dir=+1.
- DOWN:
  - If `colLat` is set: go to UP, `grabbed`=1, `upSpeed` = max(1, `UP_SPEED`−weight), position unchanged.
  - Otherwise: Y += `DOWN_SPEED`. If the result is ≥`MAX_Y`, clamp to `MAX_Y`, go to UP with `grabbed`=0 and `upSpeed`=`UP_SPEED`.
  - If `colLat` and the floor condition occur in the same frame, `colLat` wins.
- UP:
  - Y −= `upSpeed`. If the result is ≤`TOP_Y`, clamp to `TOP_Y`, go to SWING, pulse `retractDone`.
  - `grabbed` holds through the `retractDone` cycle and clears on the next cycle.
  - X is frozen in DOWN/UP. Swing direction is preserved across a drop.
- Arithmetic: 12-bit signed intermediates. Clamp before truncating to 11 bits, so positions never wrap.
- `resetN` asserted in any state restores reset values on the next edge; pending latches are dropped.

## Timing
- All outputs are registered.
- Position and state update on the clock edge ending the `startOfFrame` cycle and are visible the following cycle. They then hold for the whole frame.
- A `fire` pulse arriving in the same cycle as `startOfFrame` is latched and acted on at the next frame, not the current one.
- `retractDone` is high for exactly one cycle, coincident with the state returning to SWING.
- No back-pressure; one decision per frame.

## Structure
- Shared package `hook_pkg`:
  - `hook_state_t` enum (SWING, DOWN, UP).
  - Screen-limit constants: `SCREEN_W`=640, `SCREEN_H`=480.
  - Weight width: 4.
- One sub-module: `hook_event_latch` (sticky set/clear latch with data capture), instantiated for `fire` and for `collision`/`itemWeight`.
- Main FSM and position registers live in the top module.

## Test plan
- Reset, then 10 `startOfFrame` pulses with no fire -> `topLeftX`=320, `topLeftY`=40, `hookState`=0.
- Start at X=558 with dir +1; 2 frames -> X=560 then 558, with no value beyond 560.
- `fire` pulse in SWING, then frames -> first frame `hookState`=1 with Y=40. Y reaches 440 after 100 more frames, `hookState`=2, `grabbed`=0. After 100 more frames, Y=40 with a `retractDone` pulse.
- DOWN at Y=100, `collision` with `itemWeight`=3 -> next frame UP with `grabbed`=1 and Y=100. After 60 frames Y=40 and `retractDone`=1 with `grabbed`=1; `grabbed`=0 the next cycle.
- `itemWeight`=9 -> retract at 1 pixel/frame.
- Collision latched in the same frame Y would hit 440 -> `grabbed`=1, Y unchanged.
- Assert `resetN` mid-DOWN at Y=200 -> next cycle X=300, Y=40, SWING, latches clear. A `fire` issued in DOWN before the reset has no later effect.

Source files
------------

// File: rtl/hook_pkg.sv
// hook_pkg
// Shared types and constants for the hook motion controller.
//   hook_state_t : FSM state encoding, also driven out as hookState.
//   SCREEN_W/H   : visible screen limits in pixels.
//   WEIGHT_W     : width of the item weight bus.
//   POS_W/ARITH_W: output position width and the wider signed width
//                  used for the add/subtract-then-clamp arithmetic.
package hook_pkg;

   typedef enum logic [1:0] {
      SWING = 2'd0,
      DOWN  = 2'd1,
      UP    = 2'd2
   } hook_state_t;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;
   localparam int WEIGHT_W = 4;
   localparam int POS_W    = 11;
   localparam int ARITH_W  = 12;

   // Sign-extend an 11-bit position into the 12-bit arithmetic width.
   function automatic logic signed [ARITH_W-1:0] pos_ext(input logic signed [POS_W-1:0] v);
      return {v[POS_W-1], v};
   endfunction

endpackage

// File: rtl/hook_event_latch.sv
// hook_event_latch
// Sticky event flag with data capture.
//   clk    : system clock
//   rst_i  : synchronous active-high reset, clears flag and data
//   set_i  : raise the flag; data_i is captured only on the first set
//   clr_i  : consume the flag (wins over a simultaneous set)
//   data_i : payload sampled with the first set
//   flag_o : registered sticky flag
//   data_o : payload captured when the flag was first raised
module hook_event_latch #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_i,
   input  logic         set_i,
   input  logic         clr_i,
   input  logic [W-1:0] data_i,
   output logic         flag_o,
   output logic [W-1:0] data_o
);

   logic         flag_q, flag_d;
   logic [W-1:0] data_q, data_d;

   always_comb begin
      flag_d = flag_q;
      data_d = data_q;
      if (clr_i) begin
         flag_d = 1'b0;
      end else if (set_i) begin
         flag_d = 1'b1;
         // Keep the first event's payload if more arrive before consumption.
         if (!flag_q) data_d = data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         flag_q <= 1'b0;
         data_q <= '0;
      end else begin
         flag_q <= flag_d;
         data_q <= data_d;
      end
   end

   assign flag_o = flag_q;
   assign data_o = data_q;

endmodule

// File: rtl/hook_motion_controller.sv
// hook_motion_controller
// Moves the Gold Miner hook: swings in X while idle, drops on fire,
// retracts at a speed reduced by the grabbed item's weight.
//   clk          : system clock
//   resetN       : synchronous reset, active-high (despite the name)
//   startOfFrame : one-cycle strobe per video frame; all motion happens here
//   fire         : drop request, latched only while swinging
//   collision    : item touch, latched only while dropping
//   itemWeight   : weight of the touched item, sampled with collision
//   topLeftX/Y   : registered hook position for the drawing object
//   hookState    : registered FSM state (SWING=0, DOWN=1, UP=2)
//   grabbed      : an item is attached during UP
//   retractDone  : one-cycle pulse as the hook reaches TOP_Y
// There is no valid/ready handshake: startOfFrame is a pure strobe, the
// block never stalls, and each strobe yields exactly one decision.
module hook_motion_controller
   import hook_pkg::*;
#(
   parameter int HOME_X      = 300,
   parameter int TOP_Y       = 40,
   parameter int MIN_X       = 40,
   parameter int MAX_X       = 560,
   parameter int MAX_Y       = 440,
   parameter int SWING_SPEED = 2,
   parameter int DOWN_SPEED  = 4,
   parameter int UP_SPEED    = 4
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    startOfFrame,
   input  logic                    fire,
   input  logic                    collision,
   input  logic [WEIGHT_W-1:0]     itemWeight,
   output logic signed [POS_W-1:0] topLeftX,
   output logic signed [POS_W-1:0] topLeftY,
   output logic [1:0]              hookState,
   output logic                    grabbed,
   output logic                    retractDone
);

   localparam logic signed [ARITH_W-1:0] HOME_X_S = ARITH_W'(HOME_X);
   localparam logic signed [ARITH_W-1:0] TOP_Y_S  = ARITH_W'(TOP_Y);
   localparam logic signed [ARITH_W-1:0] MIN_X_S  = ARITH_W'(MIN_X);
   localparam logic signed [ARITH_W-1:0] MAX_X_S  = ARITH_W'(MAX_X);
   localparam logic signed [ARITH_W-1:0] MAX_Y_S  = ARITH_W'(MAX_Y);
   localparam logic signed [ARITH_W-1:0] SWING_S  = ARITH_W'(SWING_SPEED);
   localparam logic signed [ARITH_W-1:0] DOWN_S   = ARITH_W'(DOWN_SPEED);
   localparam logic signed [ARITH_W-1:0] UP_S     = ARITH_W'(UP_SPEED);

   hook_state_t                state_q, state_d;
   logic signed [POS_W-1:0]    x_q, x_d, y_q, y_d;
   logic                       dir_q, dir_d;          // 1 = moving right
   logic                       grabbed_q, grabbed_d;
   logic                       done_q, done_d;
   logic signed [ARITH_W-1:0]  up_speed_q, up_speed_d;

   logic                       fire_flag, fire_clr, fire_data_unused;
   logic                       col_flag, col_clr;
   logic [WEIGHT_W-1:0]        col_weight;

   logic signed [ARITH_W-1:0]  x_sum, y_down, y_up, weight_s;

   hook_event_latch #(.W(1)) u_fire_latch (
      .clk    (clk),
      .rst_i  (resetN),
      .set_i  (fire && (state_q == SWING)),
      .clr_i  (fire_clr),
      .data_i (1'b1),
      .flag_o (fire_flag),
      .data_o (fire_data_unused)
   );

   hook_event_latch #(.W(WEIGHT_W)) u_col_latch (
      .clk    (clk),
      .rst_i  (resetN),
      .set_i  (collision && (state_q == DOWN)),
      .clr_i  (col_clr),
      .data_i (itemWeight),
      .flag_o (col_flag),
      .data_o (col_weight)
   );

   // Candidate positions in 12-bit signed so clamping happens before
   // truncation back to 11 bits.
   assign x_sum    = dir_q ? (pos_ext(x_q) + SWING_S) : (pos_ext(x_q) - SWING_S);
   assign y_down   = pos_ext(y_q) + DOWN_S;
   assign y_up     = pos_ext(y_q) - up_speed_q;
   assign weight_s = ARITH_W'(col_weight);

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      dir_d      = dir_q;
      // grabbed survives the retractDone cycle and drops right after it.
      grabbed_d  = done_q ? 1'b0 : grabbed_q;
      done_d     = 1'b0;
      up_speed_d = up_speed_q;
      fire_clr   = 1'b0;
      col_clr    = 1'b0;

      if (startOfFrame) begin
         unique case (state_q)
            SWING: begin
               if (fire_flag) begin
                  state_d  = DOWN;
                  fire_clr = 1'b1;
               end else if (x_sum >= MAX_X_S) begin
                  x_d   = MAX_X_S[POS_W-1:0];
                  dir_d = 1'b0;
               end else if (x_sum <= MIN_X_S) begin
                  x_d   = MIN_X_S[POS_W-1:0];
                  dir_d = 1'b1;
               end else begin
                  x_d = x_sum[POS_W-1:0];
               end
            end
            DOWN: begin
               if (col_flag) begin
                  state_d    = UP;
                  grabbed_d  = 1'b1;
                  col_clr    = 1'b1;
                  up_speed_d = (weight_s >= UP_S - 12'sd1) ? 12'sd1 : (UP_S - weight_s);
               end else if (y_down >= MAX_Y_S) begin
                  y_d        = MAX_Y_S[POS_W-1:0];
                  state_d    = UP;
                  grabbed_d  = 1'b0;
                  up_speed_d = UP_S;
                  // Drop a collision arriving on this very strobe: the hook
                  // is already leaving DOWN empty-handed.
                  col_clr    = 1'b1;
               end else begin
                  y_d = y_down[POS_W-1:0];
               end
            end
            UP: begin
               if (y_up <= TOP_Y_S) begin
                  y_d     = TOP_Y_S[POS_W-1:0];
                  state_d = SWING;
                  done_d  = 1'b1;
               end else begin
                  y_d = y_up[POS_W-1:0];
               end
            end
            default: state_d = SWING;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (resetN) begin
         state_q    <= SWING;
         x_q        <= HOME_X_S[POS_W-1:0];
         y_q        <= TOP_Y_S[POS_W-1:0];
         dir_q      <= 1'b1;
         grabbed_q  <= 1'b0;
         done_q     <= 1'b0;
         up_speed_q <= UP_S;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         dir_q      <= dir_d;
         grabbed_q  <= grabbed_d;
         done_q     <= done_d;
         up_speed_q <= up_speed_d;
      end
   end

   assign topLeftX    = x_q;
   assign topLeftY    = y_q;
   assign hookState   = state_q;
   assign grabbed     = grabbed_q;
   assign retractDone = done_q;

endmodule

// File: tb/tb_hook_motion_controller.sv
// tb_hook_motion_controller
// Directed bench for hook_motion_controller. Expected output words
// {state, x, y, grabbed, retractDone} are queued as each step is driven
// and popped when the DUT's registered outputs are sampled on the
// falling edge.
module tb_hook_motion_controller;

   logic               clk = 1'b0;
   logic               resetN = 1'b1;
   logic               startOfFrame = 1'b0;
   logic               fire = 1'b0;
   logic               collision = 1'b0;
   logic [3:0]         itemWeight = 4'd0;
   logic signed [10:0] topLeftX;
   logic signed [10:0] topLeftY;
   logic [1:0]         hookState;
   logic               grabbed;
   logic               retractDone;

   logic [25:0] exp_q[$];
   int          tests = 0;
   int          fails = 0;

   hook_motion_controller dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .fire         (fire),
      .collision    (collision),
      .itemWeight   (itemWeight),
      .topLeftX     (topLeftX),
      .topLeftY     (topLeftY),
      .hookState    (hookState),
      .grabbed      (grabbed),
      .retractDone  (retractDone)
   );

   // Clock / reset
   always #5 clk = ~clk;

   function automatic logic [25:0] pk(input int st, input int x, input int y,
                                      input bit g, input bit d);
      return {2'(st), 11'(x), 11'(y), g, d};
   endfunction

   // Scoreboard compare: pop the oldest expectation, check the DUT.
   task automatic compare(input string tag);
      logic [25:0] obs;
      logic [25:0] e;
      obs = {hookState, topLeftX, topLeftY, grabbed, retractDone};
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            fails++;
            $error("FAIL %s: got st=%0d x=%0d y=%0d g=%0b d=%0b, expected st=%0d x=%0d y=%0d g=%0b d=%0b",
                   tag, obs[25:24], obs[23:13], obs[12:2], obs[1], obs[0],
                   e[25:24], e[23:13], e[12:2], e[1], e[0]);
         end
      end
   endtask

   // Driver tasks (inputs change on the falling edge).
   task automatic frame(input string tag, input logic [25:0] e);
      exp_q.push_back(e);
      @(negedge clk) startOfFrame = 1'b1;
      @(negedge clk) startOfFrame = 1'b0;
      compare(tag);
   endtask

   task automatic frames_nc(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk) startOfFrame = 1'b1;
         @(negedge clk) startOfFrame = 1'b0;
      end
   endtask

   task automatic idle_check(input string tag, input logic [25:0] e);
      exp_q.push_back(e);
      @(negedge clk);
      compare(tag);
   endtask

   task automatic check_now(input string tag, input logic [25:0] e);
      exp_q.push_back(e);
      compare(tag);
   endtask

   task automatic pulse_fire();
      @(negedge clk) fire = 1'b1;
      @(negedge clk) fire = 1'b0;
   endtask

   task automatic pulse_col(input logic [3:0] w);
      @(negedge clk) begin collision = 1'b1; itemWeight = w; end
      @(negedge clk) collision = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk) resetN = 1'b1;
      @(negedge clk) resetN = 1'b0;
   endtask

   initial begin
      // Reset
      repeat (3) @(negedge clk);
      resetN = 1'b0;
      check_now("reset", pk(0, 300, 40, 0, 0));

      // Idle swing: 10 frames -> X=320
      for (int k = 1; k <= 10; k++) frame("swing", pk(0, 300 + 2*k, 40, 0, 0));

      // Right bound: 556 -> 558 -> 560 (flip) -> 558 -> 556
      frames_nc(118);
      frame("edge_558", pk(0, 558, 40, 0, 0));
      frame("edge_560", pk(0, 560, 40, 0, 0));
      frame("edge_back", pk(0, 558, 40, 0, 0));
      frame("edge_back2", pk(0, 556, 40, 0, 0));

      // Full drop to floor, empty retract
      pulse_fire();
      frame("fire_down", pk(1, 556, 40, 0, 0));
      for (int k = 1; k <= 100; k++)
         frame("drop", pk((k == 100) ? 2 : 1, 556, 40 + 4*k, 0, 0));
      for (int k = 1; k <= 100; k++)
         frame("retract", pk((k == 100) ? 0 : 2, 556, 440 - 4*k, 0, (k == 100)));
      idle_check("done_clear", pk(0, 556, 40, 0, 0));
      frame("dir_kept", pk(0, 554, 40, 0, 0));

      // fire coincident with startOfFrame acts one frame later
      exp_q.push_back(pk(0, 552, 40, 0, 0));
      @(negedge clk) begin startOfFrame = 1'b1; fire = 1'b1; end
      @(negedge clk) begin startOfFrame = 1'b0; fire = 1'b0; end
      compare("fire_sof_same");
      frame("fire_sof_next", pk(1, 552, 40, 0, 0));

      // Grab at Y=100 with weight 3 -> 1 px/frame
      for (int k = 1; k <= 15; k++) frame("drop100", pk(1, 552, 40 + 4*k, 0, 0));
      pulse_col(4'd3);
      frame("grab_w3", pk(2, 552, 100, 1, 0));
      for (int k = 1; k <= 60; k++)
         frame("retract_w3", pk((k == 60) ? 0 : 2, 552, 100 - k, 1, (k == 60)));
      idle_check("grab_clear", pk(0, 552, 40, 0, 0));

      // Collision in SWING ignored; weight 9 captured over a later weight 1
      pulse_col(4'd7);
      pulse_fire();
      frame("fire2", pk(1, 552, 40, 0, 0));
      frame("swing_col_ign", pk(1, 552, 44, 0, 0));
      pulse_col(4'd9);
      pulse_col(4'd1);
      frame("grab_w9", pk(2, 552, 44, 1, 0));
      for (int k = 1; k <= 4; k++)
         frame("retract_w9", pk((k == 4) ? 0 : 2, 552, 44 - k, 1, (k == 4)));
      idle_check("grab_clear2", pk(0, 552, 40, 0, 0));

      // Collision latched on the frame that would hit the floor
      pulse_fire();
      frame("fire3", pk(1, 552, 40, 0, 0));
      frames_nc(98);
      frame("at_436", pk(1, 552, 436, 0, 0));
      pulse_col(4'd0);
      frame("col_wins", pk(2, 552, 436, 1, 0));
      frame("up_w0", pk(2, 552, 432, 1, 0));

      // Reset mid-DOWN at Y=200 drops pending latches
      pulse_reset();
      check_now("reset2", pk(0, 300, 40, 0, 0));
      pulse_fire();
      frame("fire4", pk(1, 300, 40, 0, 0));
      frames_nc(39);
      frame("at_200", pk(1, 300, 200, 0, 0));
      pulse_fire();
      @(negedge clk) begin collision = 1'b1; itemWeight = 4'd2; resetN = 1'b1; end
      @(negedge clk) begin collision = 1'b0; resetN = 1'b0; end
      check_now("reset_mid", pk(0, 300, 40, 0, 0));
      frame("post_rst1", pk(0, 302, 40, 0, 0));
      frame("post_rst2", pk(0, 304, 40, 0, 0));

      // Final report
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
